des_round_datapath: RTL and testbench
=====================================

// Module: des_round_datapath
// PURPOSE
//  Front end of one DES encryption pass: applies the DES initial permutation (IP) to a
//  64-bit block, splits it into L0/R0, holds a 56-bit round key, and presents E(R0).
//  Sits between block/key input staging and the key-mixer/S-box round logic.
//  Registered outputs, one clock, 1-cycle latency.
// PARAMETERS
//  BLK_W  64  block width; fixed by DES, other values unsupported
//  KEY_W  56  key width (parity bits stripped); fixed by DES
//  EXP_W  48  expansion output width; fixed by DES
// PORTS
//  clk      in   1   rising-edge clock; single clock domain
//  rst      in   1   synchronous, active-high reset
//  load_i   in   1   capture block_i/key_i this cycle
//  block_i  in   64  plaintext block; bit 63 = DES bit 1
//  key_i    in   56  round key; bit 55 = DES key bit 1
//  valid_o  out  1   outputs below hold a newly loaded result
//  l_o      out  32  L0 = IP output bits 1..32
//  r_o      out  32  R0 = IP output bits 33..64
//  exp_o    out  48  E(R0); bit 47 = E bit 1
//  key_o    out  56  registered copy of key_i, bit-for-bit
// BEHAVIOUR
//  - Bit numbering: DES position n of a W-bit vector is vector bit W-n.
//  - IP: out[n] = in[IP[n]], standard table 58 50 42 34 26 18 10 2 / 60 52 .. 4 /
//    62 .. 6 / 64 .. 8 / 57 49 .. 1 / 59 .. 3 / 61 .. 5 / 63 55 47 39 31 23 15 7.
//  - E: e[n] = R[E[n]], standard table 32 1 2 3 4 5 4 5 6 7 8 9 8 9 .. 28 29 30 31 32 1.
//  - rst=1 at a clock edge: l_o, r_o, key_o, valid_o <= 0; exp_o = E(0) = 0.
//    rst has priority over load_i.
//  - load_i=1 (rst=0): l_o/r_o <= IP(block_i) halves; key_o <= key_i;
//    valid_o <= 1 on the following cycle.
//  - load_i=0: l_o, r_o, key_o hold; valid_o <= 0 (one-cycle pulse per load).
//  - Back-to-back loads: every load accepted; valid_o stays high; latest data wins.
//  - exp_o is purely combinational from the r_o register; no extra latency.
//  - Key is passed through untouched; no rotation or PC-2 in this block.
//  - Reset mid-stream discards held data; the next load behaves as the first one.
//  - No X propagation: all registers reset, no latches.
// STRUCTURE
//  - Package des_pkg: IP_TABLE[64], E_TABLE[48] as localparam int arrays, plus
//    BLK_W/KEY_W/EXP_W constants; shared with the inverse-IP and round blocks.
//  - Sub-module des_expansion: combinational 32->48 E-box, reused by every round.
//  - IP is a generate loop over IP_TABLE in the top; registers in one always_ff.
// TESTING
//  - rst for 2 cycles -> l_o=r_o=0, exp_o=0, key_o=0, valid_o=0.
//  - load block 0x0123456789ABCDEF, key 0x00FFEEDDCCBBAA -> next cycle valid_o=1,
//    l_o=0xCC00CCFF, r_o=0xF0AAF0AA, exp_o=0x7A15557A1555, key_o=0x00FFEEDDCCBBAA.
//  - load block 0x0000000000000040 (DES bit 58) -> l_o=0x80000000, r_o=0, exp_o=0.
//  - load block 0x0200000000000000 (DES bit 7) -> l_o=0, r_o=0x00000001,
//    exp_o=0x800000000002.
//  - load all-ones block -> l_o=r_o=0xFFFFFFFF, exp_o=0xFFFFFFFFFFFF; then
//    load_i=0 -> valid_o drops, data holds.
//  - assert rst and load_i together -> all outputs 0, valid_o=0 next cycle.

Source files
------------

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module : des_pkg
// Brief  : DES widths and the IP / E permutation tables (DES 1-based positions)
// Rev    : 1.0
// ============================================================================
package des_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 56;
  localparam int EXP_W = 48;
  localparam int HALF_W = BLK_W / 2;

  localparam int IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

endpackage
`default_nettype wire

// File: rtl/des_expansion.sv
`default_nettype none
// ============================================================================
// Module : des_expansion
// Brief  : Combinational DES E-box, 32-bit half block to 48-bit expansion
// Rev    : 1.0
// ============================================================================
module des_expansion
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] i_r,
  output logic [EXP_W-1:0]  o_e
);

  // DES position n lives at vector bit (width - n)
  for (genvar n = 1; n <= EXP_W; n++) begin : g_ebit
    assign o_e[EXP_W-n] = i_r[HALF_W-E_TABLE[n-1]];
  end

endmodule
`default_nettype wire

// File: rtl/des_round_datapath.sv
`default_nettype none
// ============================================================================
// Module : des_round_datapath
// Brief  : DES front end - IP of the block, L0/R0 split, key hold, E(R0)
// Rev    : 1.0
// ============================================================================
module des_round_datapath
  import des_pkg::*;
#(
  parameter int BLK_W_P = BLK_W,
  parameter int KEY_W_P = KEY_W,
  parameter int EXP_W_P = EXP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BLK_W_P-1:0] block_i,
  input  logic [KEY_W_P-1:0] key_i,
  output logic               valid_o,
  output logic [31:0]        l_o,
  output logic [31:0]        r_o,
  output logic [EXP_W_P-1:0] exp_o,
  output logic [KEY_W_P-1:0] key_o
);

  logic [BLK_W_P-1:0] w_ip;
  logic [31:0]        r_l;
  logic [31:0]        r_r;
  logic [KEY_W_P-1:0] r_key;
  logic               r_valid;
  logic [EXP_W-1:0]   w_exp;

  for (genvar n = 1; n <= BLK_W; n++) begin : g_ipbit
    assign w_ip[BLK_W-n] = block_i[BLK_W-IP_TABLE[n-1]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l     <= '0;
      r_r     <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= load_i;
      if (load_i) begin
        r_l   <= w_ip[BLK_W_P-1:32];
        r_r   <= w_ip[31:0];
        r_key <= key_i;
      end
    end
  end

  // Expansion hangs off the R register so it shares the register latency
  des_expansion u_expansion (
    .i_r (r_r),
    .o_e (w_exp)
  );

  assign valid_o = r_valid;
  assign l_o     = r_l;
  assign r_o     = r_r;
  assign exp_o   = w_exp;
  assign key_o   = r_key;

endmodule
`default_nettype wire

// File: tb/tb_des_round_datapath.sv
`default_nettype none
// ============================================================================
// Module : tb_des_round_datapath
// Brief  : Directed vector bench for des_round_datapath
// Rev    : 1.0
// ============================================================================
module tb_des_round_datapath;

  logic         clk;
  logic         rst;
  logic         load_i;
  logic [63:0]  block_i;
  logic [55:0]  key_i;
  logic         valid_o;
  logic [31:0]  l_o;
  logic [31:0]  r_o;
  logic [47:0]  exp_o;
  logic [55:0]  key_o;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [63:0] blk;
    logic [55:0] key;
    logic [31:0] l;
    logic [31:0] r;
    logic [47:0] e;
  } vec_t;

  vec_t vecs [4];

  des_round_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_i),
    .block_i (block_i),
    .key_i   (key_i),
    .valid_o (valid_o),
    .l_o     (l_o),
    .r_o     (r_o),
    .exp_o   (exp_o),
    .key_o   (key_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] l,
                           input logic [31:0] r, input logic [47:0] e, input logic [55:0] k);
    check({tag, ".valid"}, {63'd0, valid_o}, {63'd0, v});
    check({tag, ".l"},     {32'd0, l_o},     {32'd0, l});
    check({tag, ".r"},     {32'd0, r_o},     {32'd0, r});
    check({tag, ".exp"},   {16'd0, exp_o},   {16'd0, e});
    check({tag, ".key"},   {8'd0, key_o},    {8'd0, k});
  endtask

  task automatic step(input logic rs, input logic ld, input logic [63:0] b, input logic [55:0] k);
    @(negedge clk);
    rst     = rs;
    load_i  = ld;
    block_i = b;
    key_i   = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    load_i   = 1'b0;
    block_i  = '0;
    key_i    = '0;

    vecs[0] = '{64'h0123456789ABCDEF, 56'h00FFEEDDCCBBAA,
                32'hCC00CCFF, 32'hF0AAF0AA, 48'h7A15557A1555};
    vecs[1] = '{64'h0000000000000040, 56'h123456789ABCDE,
                32'h80000000, 32'h00000000, 48'h000000000000};
    vecs[2] = '{64'h0200000000000000, 56'h00000000000001,
                32'h00000000, 32'h00000001, 48'h800000000002};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF};

    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    check_all("reset", 1'b0, 32'h0, 32'h0, 48'h0, 56'h0);

    // Back-to-back loads: valid stays high, each result replaces the last
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, vecs[i].blk, vecs[i].key);
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].l, vecs[i].r, vecs[i].e, vecs[i].key);
    end

    // Idle inputs change but must not be captured
    step(1'b0, 1'b0, 64'h0123456789ABCDEF, 56'h0);
    check_all("hold1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF);
    step(1'b0, 1'b0, 64'h0, 56'h0);
    check_all("hold2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF);

    step(1'b1, 1'b1, 64'h0123456789ABCDEF, 56'h00FFEEDDCCBBAA);
    check_all("rst_load", 1'b0, 32'h0, 32'h0, 48'h0, 56'h0);

    step(1'b0, 1'b1, vecs[2].blk, 56'hA5A5A5A5A5A5A5);
    check_all("post_rst", 1'b1, vecs[2].l, vecs[2].r, vecs[2].e, 56'hA5A5A5A5A5A5A5);
    step(1'b0, 1'b0, 64'h0, 56'h0);
    check_all("pulse_end", 1'b0, vecs[2].l, vecs[2].r, vecs[2].e, 56'hA5A5A5A5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
